fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops 32-bit words from a FIFO and sends each one as four 8N1 UART frames, byte 0 first.
// word_done pulses in the cycle after DONE, which is also the earliest IDLE cycle that can start the next read.
module fifo_uart_tx #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              word_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_word_q, shift_word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CntW-1:0]   baud_cnt_q, baud_cnt_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              word_done_q, word_done_d;
    logic              line_active;
    logic              baud_tick;
    logic              start_word;

    assign line_active = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign baud_tick   = line_active && (baud_cnt_q == CntMax);
    assign start_word  = (state_q == StIdle) && enable && !fifo_empty;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_word) state_d = StRd;
            StRd:    state_d = StCap;
            StCap:   state_d = StStart;
            StStart: if (baud_tick) state_d = StData;
            StData:  if (baud_tick && (bit_idx_q == 3'd7)) state_d = StStop;
            StStop: begin
                if (baud_tick) begin
                    state_d = (byte_idx_q == 2'd3) ? StDone : StStart;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        shift_word_d = shift_word_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = '0;
        fifo_rd_d    = start_word;
        word_done_d  = (state_q == StDone);

        if (line_active && !baud_tick) begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end

        if (state_q == StCap) begin
            shift_word_d = fifo_data;
            byte_idx_d   = '0;
        end else if ((state_q == StStop) && baud_tick && (byte_idx_q != 2'd3)) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end

        // bit_idx wraps 7 -> 0 on the last data bit, ready for the next frame
        if (state_q == StData) begin
            if (baud_tick) begin
                bit_idx_d = bit_idx_q + 3'd1;
            end
        end else begin
            bit_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_word_q <= '0;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
            fifo_rd_q    <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            shift_word_q <= shift_word_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            fifo_rd_q    <= fifo_rd_d;
            word_done_q  <= word_done_d;
        end
    end

    // Output logic
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = shift_word_q[{byte_idx_q, bit_idx_q}];
            default: tx = 1'b1;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign fifo_rd   = fifo_rd_q;
    assign word_done = word_done_q;

    // A read is only ever requested against a FIFO that was non-empty at decision time
    assert property (@(posedge clk) disable iff (reset) fifo_rd |-> $past(!fifo_empty));
    assert property (@(posedge clk) disable iff (reset) word_done |-> !busy);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model with one-cycle read latency, per-cycle line capture
// of whole words, and scenario tasks that decode the frames against hand-computed values.
module tb_fifo_uart_tx;

    localparam int CPB      = 4;
    localparam int WORD_CYC = 40 * CPB;
    localparam int WD_CYC   = 3 + WORD_CYC;  // fifo_rd high -> word_done high
    localparam int CAP_LEN  = WD_CYC + 1;    // earliest next fifo_rd

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_rd, tx, busy, word_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic tx_s   [0:CAP_LEN];
    logic wd_s   [0:CAP_LEN];
    logic rd_s   [0:CAP_LEN];
    logic busy_s [0:CAP_LEN];

    fifo_uart_tx #(
        .DATA_W       (32),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd === 1'b1 && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rd(input int limit, input string name);
        int n = 0;
        while (fifo_rd !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_start: fifo_rd=%b after %0d cycles, required 1", name, fifo_rd, n);
        end
    endtask

    // Called on the negedge where fifo_rd is high (cycle 0); records cycles 1..CAP_LEN.
    task automatic capture(input int drop_en_at);
        for (int c = 1; c <= CAP_LEN; c++) begin
            @(negedge clk);
            if (c == drop_en_at) enable = 1'b0;
            tx_s[c]   = tx;
            wd_s[c]   = word_done;
            rd_s[c]   = fifo_rd;
            busy_s[c] = busy;
        end
    endtask

    // Decodes the captured line and counts deviations from the expected per-word timeline.
    task automatic analyze(input logic exp_next_rd, output logic [31:0] w, output int frame_bad,
                           output int wd_bad, output int rd_bad, output int busy_bad);
        logic first;
        logic exp_busy;
        int   s;
        w = '0;
        frame_bad = 0;
        wd_bad = 0;
        rd_bad = 0;
        busy_bad = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) begin
                s = 2 + (10 * b + k) * CPB;
                first = tx_s[s];
                for (int j = 1; j < CPB; j++) if (tx_s[s + j] !== first) frame_bad++;
                if (k == 0 && first !== 1'b0) frame_bad++;
                if (k == 9 && first !== 1'b1) frame_bad++;
                if (k >= 1 && k <= 8) w[8 * b + k - 1] = first;
            end
        end
        for (int c = 1; c <= CAP_LEN; c++) begin
            if (wd_s[c] !== (c == WD_CYC)) wd_bad++;
            if (rd_s[c] !== ((c == CAP_LEN) ? exp_next_rd : 1'b0)) rd_bad++;
            exp_busy = (c < WD_CYC) ? 1'b1 : ((c == WD_CYC) ? 1'b0 : exp_next_rd);
            if (busy_s[c] !== exp_busy) busy_bad++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b1;
        push(32'h44332211);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++; $display("FAIL reset_tx[%0d]: got %b want 1", i, tx);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy);
            end
            checks++;
            if (fifo_rd !== 1'b0) begin
                errors++; $display("FAIL reset_fifo_rd[%0d]: got %b want 0", i, fifo_rd);
            end
            checks++;
            if (word_done !== 1'b0) begin
                errors++; $display("FAIL reset_word_done[%0d]: got %b want 0", i, word_done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_word;
        logic [31:0] w;
        logic [9:0]  exp_f;
        int fb, wdb, rdb, bb, seq_bad;
        exp_f = 10'b1000100010;  // stop, 0x11 MSB..LSB, start
        wait_rd(10, "single");
        capture(0);
        analyze(1'b0, w, fb, wdb, rdb, bb);
        seq_bad = 0;
        for (int i = 0; i < 10 * CPB; i++) if (tx_s[2 + i] !== exp_f[i / CPB]) seq_bad++;
        checks++;
        if (seq_bad != 0) begin
            errors++; $display("FAIL single_first_frame: %0d bad cycles, want 0", seq_bad);
        end
        checks++;
        if (w !== 32'h44332211) begin
            errors++; $display("FAIL single_data: got %h want 44332211", w);
        end
        checks++;
        if (fb != 0) begin
            errors++; $display("FAIL single_framing: %0d errors, want 0", fb);
        end
        checks++;
        if (wdb != 0) begin
            errors++; $display("FAIL single_word_done_at_163: %0d bad cycles, want 0", wdb);
        end
        checks++;
        if (rdb != 0) begin
            errors++; $display("FAIL single_fifo_rd_once: %0d bad cycles, want 0", rdb);
        end
        checks++;
        if (bb != 0) begin
            errors++; $display("FAIL single_busy: %0d bad cycles, want 0", bb);
        end
    endtask

    task automatic test_empty_fifo;
        int rd_bad = 0, tx_bad = 0, busy_bad = 0;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0) rd_bad++;
            if (tx !== 1'b1) tx_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        checks++;
        if (rd_bad != 0) begin
            errors++; $display("FAIL empty_fifo_rd: %0d cycles high, want 0", rd_bad);
        end
        checks++;
        if (tx_bad != 0) begin
            errors++; $display("FAIL empty_tx: %0d cycles low, want 0", tx_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL empty_busy: %0d cycles high, want 0", busy_bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        int fb, wdb, rdb, bb;
        push(32'hA5A5A5A5);
        push(32'h0000FF00);
        wait_rd(10, "b2b");
        capture(0);
        analyze(1'b1, w, fb, wdb, rdb, bb);
        checks++;
        if (w !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL b2b_word0: got %h want a5a5a5a5", w);
        end
        checks++;
        if (fb != 0 || wdb != 0) begin
            errors++; $display("FAIL b2b_word0_timing: framing=%0d done=%0d, want 0/0", fb, wdb);
        end
        checks++;
        if (rdb != 0 || bb != 0) begin
            errors++; $display("FAIL b2b_rd_gap_164: rd=%0d busy=%0d bad, want 0/0", rdb, bb);
        end
        capture(0);
        analyze(1'b0, w, fb, wdb, rdb, bb);
        checks++;
        if (w !== 32'h0000FF00) begin
            errors++; $display("FAIL b2b_word1: got %h want 0000ff00", w);
        end
        checks++;
        if (fb != 0 || wdb != 0 || rdb != 0) begin
            errors++; $display("FAIL b2b_word1_timing: frame=%0d done=%0d rd=%0d, want 0", fb, wdb, rdb);
        end
    endtask

    task automatic test_enable_drop;
        logic [31:0] w;
        int fb, wdb, rdb, bb;
        int idle_bad = 0;
        push(32'hDEADBEEF);
        push(32'h87654321);
        enable = 1'b1;
        wait_rd(10, "endrop");
        capture(20);
        analyze(1'b0, w, fb, wdb, rdb, bb);
        checks++;
        if (w !== 32'hDEADBEEF) begin
            errors++; $display("FAIL endrop_data: got %h want deadbeef", w);
        end
        checks++;
        if (fb != 0 || wdb != 0) begin
            errors++; $display("FAIL endrop_complete: frame=%0d done=%0d, want 0/0", fb, wdb);
        end
        checks++;
        if (rdb != 0) begin
            errors++; $display("FAIL endrop_no_next_rd: %0d bad cycles, want 0", rdb);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++; $display("FAIL endrop_stays_idle: %0d bad cycles, want 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_byte;
        logic [31:0] w;
        int fb, wdb, rdb, bb;
        push(32'h0F1E2D3C);  // 0x87654321 is still queued ahead of it
        enable = 1'b1;
        wait_rd(10, "midrst");
        for (int c = 1; c <= 90; c++) @(negedge clk);  // cycle 90 is inside byte 2 data
        checks++;
        if (busy !== 1'b1 || tx_s[0] === 1'bz) begin
            errors++; $display("FAIL midrst_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_abort: tx=%b busy=%b, want 1/0", tx, busy);
        end
        reset = 1'b0;
        wait_rd(5, "midrst_fresh");
        capture(0);
        analyze(1'b0, w, fb, wdb, rdb, bb);
        checks++;
        if (w !== 32'h0F1E2D3C) begin
            errors++; $display("FAIL midrst_new_word: got %h want 0f1e2d3c", w);
        end
        checks++;
        if (fb != 0 || wdb != 0) begin
            errors++; $display("FAIL midrst_new_timing: frame=%0d done=%0d, want 0/0", fb, wdb);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_empty_fifo();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
